sobel3_grad: RTL and testbench

Sobel gradient stage that directly consumes the 3-row column stream produced by the 3x3 line buffer. Each input cycle delivers one vertical 3-pixel column. The block forms a 3x3 window with replicated image borders and computes signed Gx/Gy. It outputs the saturated L1 magnitude and a 2-bit quantized direction per pixel, feeding non-maximum suppression in the Canny pipeline.

---
 rtl/sobel3_grad.sv | 276 +++++++++++++++++++++++++++
 tb/tb_sobel3_grad.sv | 506 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel3_grad.sv
// sobel3_grad: Sobel gradient stage on the 3-row column stream.
// Builds a border-replicated 3x3 window, emits gx/gy/mag/dir.
module sobel3_grad #(
    parameter int DW = 8,
    parameter int CW = 11
) (
    input  logic            clk,
    input  logic            rst_p,
    input  logic            fsync,
    input  logic            hsync,
    input  logic [3*DW-1:0] din,
    input  logic [1:0]      ini_row,
    output logic            ovalid,
    output logic            ofsync,
    output logic [DW+2:0]   gx,
    output logic [DW+2:0]   gy,
    output logic [DW-1:0]   mag,
    output logic [1:0]      dir
);

    localparam int GW = DW + 3;
    localparam int SW = DW + 4;
    localparam int PW = DW + 9;
    localparam logic [PW-1:0] K13 = PW'(13);
    localparam logic [PW-1:0] K77 = PW'(77);
    localparam logic [DW-1:0] PMAX = '1;

    typedef enum logic {
        S_IDLE,
        S_LINE
    } state_t;

    state_t r_state;
    state_t w_state_nx;

    logic            w_start;
    logic            w_accept;
    logic            w_flush;
    logic            w_emit;
    logic            r_hsync_d;
    logic [1:0]      r_ini;
    logic [1:0]      w_ini;
    logic [CW-1:0]   r_col;
    logic [CW-1:0]   w_col_idx;

    logic [DW-1:0]   w_in_t;
    logic [DW-1:0]   w_in_m;
    logic [DW-1:0]   w_in_b;
    logic [3*DW-1:0] w_in_col;

    logic [3*DW-1:0] r_wl;
    logic [3*DW-1:0] r_wc;
    logic [3*DW-1:0] r_wr;
    logic            r_v0;

    logic [DW-1:0]   w_lt, w_lm, w_lb;
    logic [DW-1:0]   w_ct, w_cb;
    logic [DW-1:0]   w_rt, w_rm, w_rb;

    logic [GW-1:0]   w_gx_p, w_gx_n;
    logic [GW-1:0]   w_gy_p, w_gy_n;
    logic [GW-1:0]   w_gx, w_gy;

    logic            r_v1;
    logic [GW-1:0]   r_gx1;
    logic [GW-1:0]   r_gy1;

    logic [GW-1:0]   w_ax, w_ay;
    logic [SW-1:0]   w_sum;
    logic [DW-1:0]   w_mag;
    logic [PW-1:0]   w_ay32;
    logic [PW-1:0]   w_ax13;
    logic [PW-1:0]   w_ax77;
    logic [1:0]      w_dir;

    logic            r_ovalid;
    logic [GW-1:0]   r_gx;
    logic [GW-1:0]   r_gy;
    logic [DW-1:0]   r_mag;
    logic [1:0]      r_dir;
    logic [2:0]      r_fs;

    // A line only begins on a rising hsync inside a valid frame.
    assign w_start = hsync & ~r_hsync_d & fsync;

    // Line tracking: accept columns while active, flush on first gap.
    always_comb begin
        w_state_nx = r_state;
        w_accept   = 1'b0;
        w_flush    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_accept   = 1'b1;
                    w_state_nx = S_LINE;
                end
            end
            S_LINE: begin
                if (hsync && fsync) begin
                    w_accept = 1'b1;
                end else begin
                    w_flush    = 1'b1;
                    w_state_nx = S_IDLE;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // Line state register and edge detector.
    always_ff @(posedge clk) begin
        if (rst_p) begin
            r_state   <= S_IDLE;
            r_hsync_d <= 1'b1;
        end else begin
            r_state   <= w_state_nx;
            r_hsync_d <= hsync;
        end
    end

    // Row flags apply for the whole line; use live value at start.
    assign w_ini  = w_start ? ini_row : r_ini;
    assign w_in_t = din[DW-1:0];
    assign w_in_m = din[2*DW-1:DW];
    assign w_in_b = din[3*DW-1:2*DW];

    assign w_in_col = {
        w_ini[1] ? w_in_m : w_in_b,
        w_in_m,
        w_ini[0] ? w_in_m : w_in_t
    };

    // Column index of the arriving column, saturating.
    always_comb begin
        w_col_idx = r_col;
        if (w_start) begin
            w_col_idx = '0;
        end else if (r_col != '1) begin
            w_col_idx = r_col + CW'(1);
        end
    end

    // Emit the previous column once its right neighbour is known.
    assign w_emit = (w_accept & (w_col_idx != '0)) | w_flush;

    // Latch row flags and column position for the current line.
    always_ff @(posedge clk) begin
        if (rst_p) begin
            r_ini <= 2'b00;
            r_col <= '0;
        end else begin
            if (w_start) begin
                r_ini <= ini_row;
            end
            if (w_accept) begin
                r_col <= w_col_idx;
            end
        end
    end

    // S0: window shift; start replicates left, flush replicates right.
    always_ff @(posedge clk) begin
        if (rst_p) begin
            r_wl <= '0;
            r_wc <= '0;
            r_wr <= '0;
            r_v0 <= 1'b0;
        end else begin
            r_v0 <= w_emit;
            if (w_start) begin
                r_wl <= w_in_col;
                r_wc <= w_in_col;
                r_wr <= w_in_col;
            end else if (w_accept) begin
                r_wl <= r_wc;
                r_wc <= r_wr;
                r_wr <= w_in_col;
            end else if (w_flush) begin
                r_wl <= r_wc;
                r_wc <= r_wr;
            end
        end
    end

    assign w_lt = r_wl[DW-1:0];
    assign w_lm = r_wl[2*DW-1:DW];
    assign w_lb = r_wl[3*DW-1:2*DW];
    assign w_ct = r_wc[DW-1:0];
    assign w_cb = r_wc[3*DW-1:2*DW];
    assign w_rt = r_wr[DW-1:0];
    assign w_rm = r_wr[2*DW-1:DW];
    assign w_rb = r_wr[3*DW-1:2*DW];

    // Weighted sums are non-negative; difference wraps to two's complement.
    assign w_gx_p = GW'(w_rt) + GW'({w_rm, 1'b0}) + GW'(w_rb);
    assign w_gx_n = GW'(w_lt) + GW'({w_lm, 1'b0}) + GW'(w_lb);
    assign w_gy_p = GW'(w_lb) + GW'({w_cb, 1'b0}) + GW'(w_rb);
    assign w_gy_n = GW'(w_lt) + GW'({w_ct, 1'b0}) + GW'(w_rt);
    assign w_gx   = w_gx_p - w_gx_n;
    assign w_gy   = w_gy_p - w_gy_n;

    // S1: register the signed gradients.
    always_ff @(posedge clk) begin
        if (rst_p) begin
            r_v1  <= 1'b0;
            r_gx1 <= '0;
            r_gy1 <= '0;
        end else begin
            r_v1 <= r_v0;
            if (r_v0) begin
                r_gx1 <= w_gx;
                r_gy1 <= w_gy;
            end
        end
    end

    assign w_ax  = r_gx1[GW-1] ? (GW'(0) - r_gx1) : r_gx1;
    assign w_ay  = r_gy1[GW-1] ? (GW'(0) - r_gy1) : r_gy1;
    assign w_sum = SW'(w_ax) + SW'(w_ay);
    assign w_mag = (w_sum > SW'(PMAX)) ? PMAX : w_sum[DW-1:0];

    // Wide enough that 77*|gx| never wraps.
    assign w_ay32 = PW'(w_ay) << 5;
    assign w_ax13 = PW'(w_ax) * K13;
    assign w_ax77 = PW'(w_ax) * K77;

    // Direction sector from tan(22.5)~13/32 and tan(67.5)~77/32.
    always_comb begin
        w_dir = 2'd3;
        if (w_ay32 <= w_ax13) begin
            w_dir = 2'd0;
        end else if (w_ay32 >= w_ax77) begin
            w_dir = 2'd2;
        end else if (r_gx1[GW-1] == r_gy1[GW-1]) begin
            w_dir = 2'd1;
        end
    end

    // S2: magnitude/direction with gradients realigned.
    always_ff @(posedge clk) begin
        if (rst_p) begin
            r_ovalid <= 1'b0;
            r_gx     <= '0;
            r_gy     <= '0;
            r_mag    <= '0;
            r_dir    <= 2'd0;
        end else begin
            r_ovalid <= r_v1;
            if (r_v1) begin
                r_gx  <= r_gx1;
                r_gy  <= r_gy1;
                r_mag <= w_mag;
                r_dir <= w_dir;
            end
        end
    end

    // Frame sync follows the three pipeline stages.
    always_ff @(posedge clk) begin
        if (rst_p) begin
            r_fs <= 3'b000;
        end else begin
            r_fs <= {r_fs[1:0], fsync};
        end
    end

    assign ovalid = r_ovalid;
    assign ofsync = r_fs[2];
    assign gx     = r_gx;
    assign gy     = r_gy;
    assign mag    = r_mag;
    assign dir    = r_dir;

endmodule

// File: tb/tb_sobel3_grad.sv
// Testbench for sobel3_grad: directed and random lines checked
// against a whole-line reference model of the Sobel window.
module tb_sobel3_grad;

    logic        clk = 1'b0;
    logic        rst_p;
    logic        fsync;
    logic        hsync;
    logic [23:0] din;
    logic [1:0]  ini_row;
    logic        ovalid;
    logic        ofsync;
    logic [10:0] gx;
    logic [10:0] gy;
    logic [7:0]  mag;
    logic [1:0]  dir;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_start;
    int last_flush;

    int pt[64];
    int pm[64];
    int pb[64];

    logic [31:0] exp_q[$];
    logic [31:0] cap_q[$];
    int          cap_cyc[$];

    sobel3_grad #(.DW(8), .CW(11)) dut (
        .clk    (clk),
        .rst_p  (rst_p),
        .fsync  (fsync),
        .hsync  (hsync),
        .din    (din),
        .ini_row(ini_row),
        .ovalid (ovalid),
        .ofsync (ofsync),
        .gx     (gx),
        .gy     (gy),
        .mag    (mag),
        .dir    (dir)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ovalid === 1'b1) begin
            cap_q.push_back({gx, gy, mag, dir});
            cap_cyc.push_back(cyc);
        end
    end

    // Expected pixels of one whole line, straight from the Sobel rules.
    function automatic void model_line(input int w, input logic [1:0] ini);
        int t[64];
        int m[64];
        int b[64];
        for (int c = 0; c < w; c++) begin
            m[c] = pm[c];
            t[c] = ini[0] ? pm[c] : pt[c];
            b[c] = ini[1] ? pm[c] : pb[c];
        end
        for (int c = 0; c < w; c++) begin
            int l, r, sx, sy, ax, ay, mg, d;
            logic [10:0] vx, vy;
            l  = (c == 0) ? 0 : c - 1;
            r  = (c == w - 1) ? c : c + 1;
            sx = (t[r] + 2 * m[r] + b[r]) - (t[l] + 2 * m[l] + b[l]);
            sy = (b[l] + 2 * b[c] + b[r]) - (t[l] + 2 * t[c] + t[r]);
            ax = (sx < 0) ? -sx : sx;
            ay = (sy < 0) ? -sy : sy;
            mg = (ax + ay > 255) ? 255 : ax + ay;
            if (32 * ay <= 13 * ax) d = 0;
            else if (32 * ay >= 77 * ax) d = 2;
            else if ((sx < 0) == (sy < 0)) d = 1;
            else d = 3;
            vx = sx[10:0];
            vy = sy[10:0];
            exp_q.push_back({vx, vy, mg[7:0], d[1:0]});
        end
    endfunction

    task automatic clear_q();
        exp_q.delete();
        cap_q.delete();
        cap_cyc.delete();
    endtask

    task automatic rand_pix(input int w);
        for (int c = 0; c < w; c++) begin
            pt[c] = $urandom_range(0, 255);
            pm[c] = $urandom_range(0, 255);
            pb[c] = $urandom_range(0, 255);
        end
    endtask

    task automatic send_line(input int w, input logic [1:0] ini,
                             input int gap);
        for (int c = 0; c < w; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) last_start = cyc;
            fsync   = 1'b1;
            hsync   = 1'b1;
            ini_row = ini;
            din     = {8'(pb[c]), 8'(pm[c]), 8'(pt[c])};
        end
        @(posedge clk);
        #1;
        last_flush = cyc;
        hsync = 1'b0;
        din   = '0;
        for (int g = 1; g < gap; g++) @(posedge clk);
    endtask

    task automatic drain();
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_p   = 1'b1;
        fsync   = 1'b0;
        hsync   = 1'b0;
        din     = '0;
        ini_row = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({ovalid, ofsync, gx, gy, mag, dir} !== 35'd0) begin
            failures++;
            $display("FAIL reset_outs got=%h exp=0",
                     {ovalid, ofsync, gx, gy, mag, dir});
        end
        @(posedge clk);
        #1;
        rst_p = 1'b0;
    endtask

    task automatic test_ofsync();
        logic h[0:31];
        for (int i = 0; i < 24; i++) begin
            @(posedge clk);
            #1;
            fsync = 1'($urandom_range(0, 1));
            h[i]  = fsync;
            @(negedge clk);
            if (i >= 3) begin
                checks++;
                if (ofsync !== h[i-3]) begin
                    failures++;
                    $display("FAIL ofsync_c%0d got=%b exp=%b",
                             i, ofsync, h[i-3]);
                end
            end
        end
        @(posedge clk);
        #1;
        fsync = 1'b1;
        drain();
    endtask

    task automatic test_constant();
        clear_q();
        for (int c = 0; c < 16; c++) begin
            pt[c] = 100;
            pm[c] = 100;
            pb[c] = 100;
        end
        for (int ln = 0; ln < 8; ln++) begin
            logic [1:0] ini;
            ini = (ln == 0) ? 2'b01 : ((ln == 7) ? 2'b10 : 2'b00);
            model_line(16, ini);
            send_line(16, ini, 2);
        end
        drain();
        checks++;
        if (cap_q.size() != 128) begin
            failures++;
            $display("FAIL const_count got=%0d exp=128", cap_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= cap_q.size() || cap_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL const_px%0d got=%h exp=%h", i,
                         (i < cap_q.size()) ? cap_q[i] : 32'hx, exp_q[i]);
            end
        end
    endtask

    task automatic test_vstep();
        logic [31:0] edge_px;
        edge_px = {11'd1020, 11'd0, 8'd255, 2'd0};
        clear_q();
        for (int c = 0; c < 16; c++) begin
            pt[c] = (c < 8) ? 0 : 255;
            pm[c] = pt[c];
            pb[c] = pt[c];
        end
        model_line(16, 2'b00);
        send_line(16, 2'b00, 2);
        drain();
        checks++;
        if (cap_q[7] !== edge_px || cap_q[8] !== edge_px) begin
            failures++;
            $display("FAIL vstep_edge got=%h,%h exp=%h",
                     cap_q[7], cap_q[8], edge_px);
        end
        checks++;
        if (cap_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL vstep_count got=%0d exp=%0d",
                     cap_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= cap_q.size() || cap_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL vstep_px%0d got=%h exp=%h", i,
                         (i < cap_q.size()) ? cap_q[i] : 32'hx, exp_q[i]);
            end
        end
    endtask

    task automatic test_hstep();
        logic [31:0] hs_px;
        hs_px = {11'd0, 11'd1020, 8'd255, 2'd2};
        clear_q();
        for (int c = 0; c < 16; c++) begin
            pt[c] = 0;
            pm[c] = 255;
            pb[c] = 255;
        end
        model_line(16, 2'b00);
        send_line(16, 2'b00, 2);
        model_line(16, 2'b01);
        send_line(16, 2'b01, 2);
        drain();
        checks++;
        if (cap_q[5] !== hs_px) begin
            failures++;
            $display("FAIL hstep_mid got=%h exp=%h", cap_q[5], hs_px);
        end
        checks++;
        if (cap_q[21] !== 32'd0) begin
            failures++;
            $display("FAIL hstep_toprep got=%h exp=0", cap_q[21]);
        end
        checks++;
        if (cap_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL hstep_count got=%0d exp=%0d",
                     cap_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= cap_q.size() || cap_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL hstep_px%0d got=%h exp=%h", i,
                         (i < cap_q.size()) ? cap_q[i] : 32'hx, exp_q[i]);
            end
        end
    endtask

    task automatic test_ramps();
        logic [31:0] r1_px;
        logic [31:0] r3_px;
        logic [10:0] n80;
        n80   = 11'd0 - 11'd80;
        r1_px = {11'd80, 11'd80, 8'd160, 2'd1};
        r3_px = {11'd80, n80, 8'd160, 2'd3};
        clear_q();
        for (int c = 0; c < 16; c++) begin
            pt[c] = 10 * c + 40;
            pm[c] = 10 * c + 50;
            pb[c] = 10 * c + 60;
        end
        model_line(16, 2'b00);
        send_line(16, 2'b00, 2);
        for (int c = 0; c < 16; c++) begin
            pt[c] = 10 * c + 60;
            pm[c] = 10 * c + 50;
            pb[c] = 10 * c + 40;
        end
        model_line(16, 2'b00);
        send_line(16, 2'b00, 2);
        drain();
        checks++;
        if (cap_q[7] !== r1_px) begin
            failures++;
            $display("FAIL ramp45 got=%h exp=%h", cap_q[7], r1_px);
        end
        checks++;
        if (cap_q[23] !== r3_px) begin
            failures++;
            $display("FAIL ramp135 got=%h exp=%h", cap_q[23], r3_px);
        end
        checks++;
        if (cap_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL ramp_count got=%0d exp=%0d",
                     cap_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= cap_q.size() || cap_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL ramp_px%0d got=%h exp=%h", i,
                         (i < cap_q.size()) ? cap_q[i] : 32'hx, exp_q[i]);
            end
        end
    endtask

    task automatic test_latency();
        clear_q();
        rand_pix(3);
        model_line(3, 2'b00);
        send_line(3, 2'b00, 2);
        drain();
        checks++;
        if (cap_q.size() != 3) begin
            failures++;
            $display("FAIL lat_count got=%0d exp=3", cap_q.size());
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= cap_cyc.size() || cap_cyc[i] != last_start + 4 + i ||
                cap_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL lat_px%0d got=%h@%0d exp=%h@%0d", i,
                         (i < cap_q.size()) ? cap_q[i] : 32'hx,
                         (i < cap_cyc.size()) ? cap_cyc[i] : -1,
                         exp_q[i], last_start + 4 + i);
            end
        end
    endtask

    task automatic test_one_pixel();
        clear_q();
        rand_pix(1);
        model_line(1, 2'($urandom_range(0, 3)));
        send_line(1, 2'b00, 2);
        exp_q.delete();
        model_line(1, 2'b00);
        drain();
        checks++;
        if (cap_q.size() != 1) begin
            failures++;
            $display("FAIL onepx_count got=%0d exp=1", cap_q.size());
        end else begin
            checks++;
            if (cap_cyc[0] != last_flush + 3 || cap_q[0] !== exp_q[0]) begin
                failures++;
                $display("FAIL onepx got=%h@%0d exp=%h@%0d",
                         cap_q[0], cap_cyc[0], exp_q[0], last_flush + 3);
            end
        end
    endtask

    task automatic test_lines(input string tag, input int n,
                              input int wmax, input int gmax);
        clear_q();
        for (int ln = 0; ln < n; ln++) begin
            int w;
            logic [1:0] ini;
            w   = $urandom_range(1, wmax);
            ini = 2'($urandom_range(0, 3));
            rand_pix(w);
            model_line(w, ini);
            send_line(w, ini, $urandom_range(1, gmax));
        end
        drain();
        checks++;
        if (cap_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL %s_count got=%0d exp=%0d",
                     tag, cap_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= cap_q.size() || cap_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL %s_px%0d got=%h exp=%h", tag, i,
                         (i < cap_q.size()) ? cap_q[i] : 32'hx, exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_midline();
        clear_q();
        rand_pix(10);
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            fsync   = 1'b1;
            hsync   = 1'b1;
            ini_row = 2'b00;
            din     = {8'(pb[c]), 8'(pm[c]), 8'(pt[c])};
            if (c == 5) rst_p = 1'b1;
        end
        @(posedge clk);
        #1;
        rst_p = 1'b0;
        din   = {8'(pb[6]), 8'(pm[6]), 8'(pt[6])};
        @(negedge clk);
        checks++;
        if ({ovalid, ofsync, gx, gy, mag, dir} !== 35'd0) begin
            failures++;
            $display("FAIL rst_mid_outs got=%h exp=0",
                     {ovalid, ofsync, gx, gy, mag, dir});
        end
        clear_q();
        for (int c = 7; c < 10; c++) begin
            @(posedge clk);
            #1;
            din = {8'(pb[c]), 8'(pm[c]), 8'(pt[c])};
        end
        @(posedge clk);
        #1;
        hsync = 1'b0;
        drain();
        checks++;
        if (cap_q.size() != 0) begin
            failures++;
            $display("FAIL rst_mid_quiet got=%0d exp=0", cap_q.size());
        end
        clear_q();
        rand_pix(8);
        model_line(8, 2'b00);
        send_line(8, 2'b00, 2);
        drain();
        checks++;
        if (cap_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL rst_rec_count got=%0d exp=%0d",
                     cap_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= cap_q.size() || cap_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL rst_rec_px%0d got=%h exp=%h", i,
                         (i < cap_q.size()) ? cap_q[i] : 32'hx, exp_q[i]);
            end
        end
    endtask

    task automatic test_fsync_abort();
        clear_q();
        rand_pix(10);
        model_line(6, 2'b00);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            fsync   = (c < 6);
            hsync   = 1'b1;
            ini_row = 2'b00;
            din     = {8'(pb[c]), 8'(pm[c]), 8'(pt[c])};
        end
        @(posedge clk);
        #1;
        hsync = 1'b0;
        @(posedge clk);
        #1;
        fsync = 1'b1;
        drain();
        checks++;
        if (cap_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL abort_count got=%0d exp=%0d",
                     cap_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= cap_q.size() || cap_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL abort_px%0d got=%h exp=%h", i,
                         (i < cap_q.size()) ? cap_q[i] : 32'hx, exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ofsync();
        test_constant();
        test_vstep();
        test_hstep();
        test_ramps();
        test_latency();
        test_one_pixel();
        test_lines("b2b", 8, 12, 1);
        test_lines("rand", 12, 24, 3);
        test_reset_midline();
        test_fsync_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
